// File: rtl/redundant_pkg.sv
// Shared types and widths for the dual-replica execution sequencer.
package redundant_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int RETRY_W  = 3;
  localparam int LAT_W    = 4;
  localparam int ERRCNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; cleared only by asynchronous reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/redundant_exec_ctrl.sv
// Issue/compare/retry sequencer for a dual-replica datapath.
// Optional mismatch counter port err_count is built when REDUNDANT_ERR_COUNT_EN is defined.
module redundant_exec_ctrl
  import redundant_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int LATENCY   = 1,
  parameter int MAX_RETRY = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic [WIDTH-1:0]   dp_in,
  output logic               dp_start,
  input  logic [WIDTH-1:0]   dp_res_a,
  input  logic [WIDTH-1:0]   dp_res_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic [2:0]         out_retries
`ifdef REDUNDANT_ERR_COUNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  localparam logic [RETRY_W-1:0] MAX_R    = RETRY_W'(MAX_RETRY);
  localparam logic [LAT_W-1:0]   LAT_LOAD = LAT_W'(LATENCY - 1);

  state_t             state, state_nxt;
  logic [RETRY_W-1:0] retry_cnt;
  logic [LAT_W-1:0]   lat_cnt;
  logic               mismatch;
  logic               sample;

  assign mismatch = (dp_res_a != dp_res_b);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    dp_start  = 1'b0;
    out_valid = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        dp_start  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          sample = 1'b1;
          if (mismatch && (retry_cnt != MAX_R)) state_nxt = ISSUE;
          else                                  state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, counters and result registers; results only change on the final sample edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dp_in       <= '0;
      retry_cnt   <= '0;
      lat_cnt     <= '0;
      out_data    <= '0;
      out_err     <= 1'b0;
      out_retries <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dp_in     <= in_data;
            retry_cnt <= '0;
          end
        end
        ISSUE: lat_cnt <= LAT_LOAD;
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end else if (mismatch && (retry_cnt != MAX_R)) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
          end else begin
            out_data    <= dp_res_a;
            out_err     <= mismatch;
            out_retries <= retry_cnt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REDUNDANT_ERR_COUNT_EN
  sat_counter #(
    .W(ERRCNT_W)
  ) u_err_count (
    .clock (clock),
    .reset (reset),
    .inc   (sample && mismatch),
    .count (err_count)
  );
`endif

endmodule

// File: tb/tb_redundant_exec_ctrl.sv
// Bench for redundant_exec_ctrl: replicas compute x+1, replica B can be corrupted per attempt.
module tb_redundant_exec_ctrl;

  localparam int WIDTH     = 2;
  localparam int LATENCY   = 1;
  localparam int MAX_RETRY = 3;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] dp_in;
  logic             dp_start;
  logic [WIDTH-1:0] dp_res_a;
  logic [WIDTH-1:0] dp_res_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic [2:0]       out_retries;
`ifdef REDUNDANT_ERR_COUNT_EN
  logic [7:0]       err_count;
`endif

  int         n_chk  = 0;
  int         n_pass = 0;
  int         tot_pulses = 0;
  int         base = 0;
  int         fidx;
  logic [7:0] fault_mask = 8'h00;

  redundant_exec_ctrl #(
    .WIDTH(WIDTH),
    .LATENCY(LATENCY),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .dp_in       (dp_in),
    .dp_start    (dp_start),
    .dp_res_a    (dp_res_a),
    .dp_res_b    (dp_res_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_err     (out_err),
    .out_retries (out_retries)
`ifdef REDUNDANT_ERR_COUNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (dp_start) tot_pulses <= tot_pulses + 1;

  // Replica model: attempt k of the current request corrupts B when fault_mask[k] is set.
  always_comb begin
    dp_res_a = 2'(dp_in + 2'd1);
    dp_res_b = dp_res_a;
    fidx     = tot_pulses - base - 1;
    if (fidx >= 0 && fidx < 8 && fault_mask[fidx[2:0]]) dp_res_b = dp_res_a ^ 2'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic [1:0] d;
    logic       e;
    logic [2:0] r;
    int         lat;
  } exp_t;

  function automatic exp_t model(input logic [1:0] x, input logic [7:0] mask);
    exp_t o;
    int   att;
    att = 0;
    while (att <= MAX_RETRY && mask[att]) att++;
    o.d = 2'(x + 2'd1);
    if (att > MAX_RETRY) begin
      o.e   = 1'b1;
      o.r   = 3'(MAX_RETRY);
      o.lat = (MAX_RETRY + 1) * (LATENCY + 1) + 1;
    end else begin
      o.e   = 1'b0;
      o.r   = 3'(att);
      o.lat = (att + 1) * (LATENCY + 1) + 1;
    end
    return o;
  endfunction

  task automatic run_req(input logic [1:0] x, input logic [7:0] mask, input int bp,
                         input logic [1:0] e_data, input logic e_err, input logic [2:0] e_ret,
                         input int e_lat);
    int   n;
    logic dpok;
    logic stable;
    int   e_mis;
    logic [7:0] ec0;
    ec0 = 8'd0;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_data    = x;
    in_valid   = 1'b1;
    fault_mask = mask;
    base       = tot_pulses;
`ifdef REDUNDANT_ERR_COUNT_EN
    ec0 = err_count;
`endif
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = ~x;
    n    = 0;
    dpok = 1'b1;
    do begin
      @(negedge clock);
      n++;
      if (dp_in !== x) dpok = 1'b0;
    end while (!out_valid && n < 200);
    check("latency", n, e_lat);
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("out_data", {30'd0, out_data}, {30'd0, e_data});
    check("out_err", {31'd0, out_err}, {31'd0, e_err});
    check("out_retries", {29'd0, out_retries}, {29'd0, e_ret});
    check("dp_start_pulses", tot_pulses - base, {29'd0, e_ret} + 1);
    check("dp_in_hold", {31'd0, dpok}, 32'd1);
    e_mis = e_err ? (e_ret + 1) : e_ret;
`ifdef REDUNDANT_ERR_COUNT_EN
    check("err_count_delta", {24'd0, 8'(err_count - ec0)}, e_mis);
`else
    if (ec0 != 8'd0 && e_mis < 0) check("err_count_delta", 32'd0, 32'd1);
`endif
    if (bp > 0) begin
      stable = 1'b1;
      for (int i = 0; i < bp; i++) begin
        @(negedge clock);
        if (!out_valid || out_data !== e_data || out_err !== e_err ||
            out_retries !== e_ret || in_ready) stable = 1'b0;
      end
      check("backpressure_hold", {31'd0, stable}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_after", {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [1:0] x;
    logic [7:0] mask;
    int         bp;
    logic [1:0] e_data;
    logic       e_err;
    logic [2:0] e_ret;
    int         e_lat;
  } vec_t;

  vec_t vecs[5];
  exp_t ex;
  logic seen;
  logic [1:0] rx;
  logic [7:0] rm;

  initial begin
    vecs[0] = '{2'd2, 8'h00, 0, 2'd3, 1'b0, 3'd0, 3};  // clean
    vecs[1] = '{2'd3, 8'h00, 0, 2'd0, 1'b0, 3'd0, 3};  // wrap-around
    vecs[2] = '{2'd1, 8'h03, 0, 2'd2, 1'b0, 3'd2, 7};  // transient fault
    vecs[3] = '{2'd0, 8'hFF, 0, 2'd1, 1'b1, 3'd3, 9};  // persistent fault
    vecs[4] = '{2'd2, 8'h00, 5, 2'd3, 1'b0, 3'd0, 3};  // backpressure

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 2'd0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dp_start", {31'd0, dp_start}, 32'd0);
    check("rst_dp_in", {30'd0, dp_in}, 32'd0);
    check("rst_out_data", {30'd0, out_data}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_out_retries", {29'd0, out_retries}, 32'd0);
`ifdef REDUNDANT_ERR_COUNT_EN
    check("rst_err_count", {24'd0, err_count}, 32'd0);
`endif
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 5; i++)
      run_req(vecs[i].x, vecs[i].mask, vecs[i].bp, vecs[i].e_data, vecs[i].e_err,
              vecs[i].e_ret, vecs[i].e_lat);

    // Async reset while waiting for the replicas.
    @(negedge clock);
    in_data    = 2'd1;
    in_valid   = 1'b1;
    fault_mask = 8'h00;
    base       = tot_pulses;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_dp_start", {31'd0, dp_start}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_dp_in", {30'd0, dp_in}, 32'd0);
    check("mid_rst_out_data", {30'd0, out_data}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_output", {31'd0, seen}, 32'd0);
    run_req(2'd1, 8'h00, 0, 2'd2, 1'b0, 3'd0, 3);

    for (int i = 0; i < 24; i++) begin
      rx = 2'($urandom_range(0, 3));
      rm = 8'($urandom_range(0, 15));
      ex = model(rx, rm);
      run_req(rx, rm, int'($urandom_range(0, 3)), ex.d, ex.e, ex.r, ex.lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/redundant_exec_ctrl.md
Name: redundant_exec_ctrl

Overview:
- Sequencer for the dual-replica compute datapath.
- Accepts one operand at a time over a valid/ready handshake and holds it stable on the replicas' shared input.
- Waits a fixed datapath latency, then compares the two replica results.
- On mismatch it re-issues the operation up to MAX_RETRY times, then returns the agreed result or an error-flagged result over a second valid/ready handshake. Sits between the top-level I/O and the replicated datapath.

Parameters:
- WIDTH, 2: operand/result width in bits.
- LATENCY, 1: datapath cycles from dp_start to valid results; legal range 1..15.
- MAX_RETRY, 3: maximum re-issues after the first attempt; legal range 0..7.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  request operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  WIDTH  request operand.
- dp_in  out  WIDTH  operand driven to both replicas.
- dp_start  out  1  one-cycle issue pulse to the datapath.
- dp_res_a  in  WIDTH  replica A result.
- dp_res_b  in  WIDTH  replica B result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result (replica A value).
- out_err  out  1  replicas never agreed.
- out_retries  out  3  re-issues used for this result.
- err_count  out  8  saturating mismatch counter; present only with REDUNDANT_ERR_COUNT_EN.

Behaviour:
- Reset (async, active-high): clock is one clock domain; reset is asynchronous and active-high.
  - State goes to IDLE.
  - dp_in=0, dp_start=0, out_valid=0, out_data=0, out_err=0, out_retries=0, internal retry and latency counters=0.
  - in_ready=1 once in IDLE.
  - Reset mid-operation abandons the request with no output.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1 and only here.
  - in_valid&&in_ready at an edge latches in_data into the operand register, clears the retry count, and moves to ISSUE.
- ISSUE (one cycle):
  - dp_start=1.
  - Latency counter loads LATENCY-1.
  - Moves to WAIT.
- WAIT (LATENCY cycles):
  - Counter decrements each cycle.
  - On the edge where the counter is 0, compare dp_res_a with dp_res_b:
    - Equal: out_data<=dp_res_a, out_err<=0, move to DONE.
    - Unequal and retry count < MAX_RETRY: increment retry count, move to ISSUE.
    - Unequal and retry count == MAX_RETRY: out_data<=dp_res_a, out_err<=1, move to DONE.
- DONE:
  - out_valid=1; out_data, out_err and out_retries are held stable until out_valid&&out_ready.
  - Then move to IDLE; out_valid drops the next cycle.
  - in_ready stays 0 in DONE, so there is no same-cycle accept.
- dp_in holds the operand register from acceptance until the next accept; it never changes during an operation.
- dp_res_* are ignored outside the sample edge.
- Latency with a first-try match: out_valid rises LATENCY+2 cycles after the accept edge (3 cycles for the default LATENCY).
- Each retry adds LATENCY+1 cycles.
- Minimum request interval is LATENCY+3 cycles.
- out_retries reflects the retry count at the transition into DONE.
- MAX_RETRY=0: a single attempt; any mismatch goes directly to out_err=1.

Optional Feature:
- Macro: REDUNDANT_ERR_COUNT_EN.
- Defined:
  - err_count port exists, reset to 0.
  - Increments by 1 on every mismatching sample edge, including retried ones.
  - Saturates at 255 and is never cleared except by reset.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package redundant_pkg holds:
  - the state enum type (IDLE, ISSUE, WAIT, DONE);
  - RETRY_W=3, LAT_W=4 and ERRCNT_W=8 constants.
- One sub-module, sat_counter (parameterized width, inc, saturate, async reset), is instantiated for err_count.
- FSM, latency counter and operand register stay in the top module.

Test Plan (WIDTH=2, LATENCY=1, MAX_RETRY=3, replicas compute x+1):
- Clean request: in_data=2 → out_valid 3 cycles after accept, out_data=3, out_err=0, out_retries=0; dp_start pulsed exactly once.
- Wrap-around: in_data=3 → out_data=0, out_err=0.
- Transient fault: force dp_res_b^=1 on the first two samples, in_data=1 → out_data=2, out_err=0, out_retries=2; dp_start pulsed 3 times; err_count=2 when enabled.
- Persistent fault: force dp_res_b^=1 on every sample → out_err=1, out_retries=3, 4 dp_start pulses; err_count=4 when enabled.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid/out_data stable, in_ready=0 throughout; after release, in_ready=1 one cycle later.
- Async reset asserted mid-WAIT (between edges) → outputs reset immediately, no out_valid; the next request completes normally.
